i2c_sequencer: RTL and testbench
================================

I2C_SEQUENCER -- requirements
Module: i2c_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter MAX_BYTES, default 4, giving the maximum data bytes per transfer.
REQ-003 clk  in  1  single block clock; all logic synchronous to its rising edge.
REQ-004 reset_n  in  1  reset; synchronous and active-low.
REQ-005 req  in  NUM_REQ  per-requester transfer request, held until done.
REQ-006 dev_addr  in  NUM_REQ*7  per-requester 7-bit device address.
REQ-007 rnw  in  NUM_REQ  per-requester direction; 1 = read.
REQ-008 len  in  NUM_REQ*3  per-requester byte count, 1..MAX_BYTES; 0 treated as 1.
REQ-009 wdata  in  NUM_REQ*8*MAX_BYTES  per-requester write data; byte 0 = bits [7:0], sent first.
REQ-010 grant  out  NUM_REQ  one-hot owner of the current transfer.
REQ-011 done  out  1  one-cycle pulse at transfer end, qualified by grant.
REQ-012 err  out  1  valid with done; 1 = address NACK, data NACK or arbitration lost.
REQ-013 rdata  out  8*MAX_BYTES  read bytes, first byte in [7:0]; valid with done.
REQ-014 bc_start, bc_stop, bc_read, bc_write, bc_ack_in  out  1 each  command to the I2C byte controller.
REQ-015 bc_din  out  8  byte to transmit.
REQ-016 bc_cmd_ack  in  1  byte controller command-complete pulse.
REQ-017 bc_ack_out  in  1  received ACK bit; 1 = NACK.
REQ-018 bc_dout  in  8  received byte, valid with bc_cmd_ack.
REQ-019 bc_al  in  1  arbitration-lost pulse.

Function
REQ-020 The FSM SHALL have states IDLE, ADDR, DATA, STOP, DONE.
REQ-021 In IDLE with any req high, the block SHALL grant round-robin: the lowest index above the last granted index, wrapping. It SHALL latch that requester's addr/rnw/len/wdata, set grant and enter ADDR.
REQ-022 ADDR SHALL drive bc_start=1, bc_write=1 and bc_din={addr,rnw} until bc_cmd_ack.
REQ-023 On bc_cmd_ack in ADDR: if bc_ack_out=1, the FSM SHALL set err and go to STOP; otherwise it SHALL go to DATA.
REQ-024 For each byte in DATA, the block SHALL drive bc_write=1 with bc_din=byte[i] (write), or bc_read=1 (read).
REQ-025 During a read, bc_ack_in SHALL be 0, except 1 (NACK) on the last byte.
REQ-026 bc_stop SHALL be asserted together with the last byte's command.
REQ-027 On each DATA bc_cmd_ack, a read SHALL store bc_dout into byte[i].
REQ-028 On a write DATA bc_cmd_ack with bc_ack_out=1 before the last byte, the block SHALL set err and go to STOP.
REQ-029 After the last byte's ack, the FSM SHALL go to DONE.
REQ-030 STOP SHALL drive bc_stop=1 alone until bc_cmd_ack, then go to DONE.
REQ-031 bc_al in any non-IDLE state SHALL set err, drop all commands the next cycle and go directly to DONE with no STOP.
REQ-032 Command outputs SHALL be registered and deasserted in the cycle after bc_cmd_ack is sampled; the next command MAY be driven in that same cycle; commands are never held across an ack.
REQ-033 DONE SHALL pulse done for one cycle with rdata/err valid, then clear grant, record the granted index for rotation, and return to IDLE.
REQ-034 Latency from grant to first command SHALL be 0 cycles (command asserted in the cycle grant rises); from final ack to done, 1 cycle.
REQ-035 Unread rdata bytes SHALL be 0; rdata SHALL hold its value until the next done.
REQ-036 A req dropped mid-transfer SHALL be ignored; the transfer completes.

Reset
REQ-037 With reset_n=0 at a clock edge, the FSM SHALL go to IDLE and grant, done, err, rdata, all bc_* outputs SHALL be 0; the rotation pointer SHALL point so requester 0 has top priority.
REQ-038 Reset mid-transfer SHALL abandon the bus with no STOP; recovery is the byte controller's responsibility.

Structure
REQ-039 The state enum and I2C command-bit constants SHALL live in the shared package i2c_pkg.
REQ-040 The round-robin grant logic SHALL be the single sub-module rr_arbiter (parameter N).

Verification
REQ-041 Req0 write addr 0x50, len 2, wdata 0xBEEF, slave ACKs -> bytes 0xA0, 0xEF, 0xBE; bc_stop on the 0xBE command; done with err=0.
REQ-042 Req2 read addr 0x1D, len 3, slave returns 0x11, 0x22, 0x33 -> bc_ack_in 0,0,1; rdata=0x00332211; err=0.
REQ-043 Address NACK on addr 0x7F -> STOP-only command issued; done with err=1; no data command.
REQ-044 req=4'b1111 held continuously -> grants rotate 0,1,2,3,0; no requester is granted twice in a row.
REQ-045 bc_al during the second data byte -> no bc_stop; done with err=1 on the following cycle.
REQ-046 reset_n low during DATA -> next cycle all outputs 0, FSM in IDLE; the next grant goes to requester 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state type and byte-controller command encoding for the I2C sequencer
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, STOP, DONE} state_t;
  localparam logic [4:0] CMD_NONE  = 5'b00000;
  localparam logic [4:0] CMD_START = 5'b10000;
  localparam logic [4:0] CMD_STOP  = 5'b01000;
  localparam logic [4:0] CMD_READ  = 5'b00100;
  localparam logic [4:0] CMD_WRITE = 5'b00010;
  localparam logic [4:0] CMD_ACK   = 5'b00001;
  function automatic logic [4:0] data_cmd(input logic rd, input logic last);
    return (rd ? CMD_READ : CMD_WRITE) | (last ? (rd ? (CMD_STOP | CMD_ACK) : CMD_STOP) : CMD_NONE);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant, lowest index above the last recorded owner wins
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  input  logic [$clog2(N)-1:0] last_in,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] last, j;
  always_ff @(posedge clk)
    if (!reset_n) last <= IW'(N - 1);
    else if (advance) last <= last_in;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    any = 1'b0;
    j = '0;
    for (int i = N; i >= 1; i--) begin
      j = IW'((int'(last) + i) % N);
      if (req[j]) begin
        any = 1'b1;
        gnt_idx = j;
      end
    end
    if (any) gnt[gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/i2c_sequencer.sv
// i2c_sequencer: arbitrates requesters and sequences address/data/stop commands to an I2C byte controller
module i2c_sequencer import i2c_pkg::*; #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BYTES = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*7-1:0]           dev_addr,
  input  logic [NUM_REQ-1:0]             rnw,
  input  logic [NUM_REQ*3-1:0]           len,
  input  logic [NUM_REQ*8*MAX_BYTES-1:0] wdata,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           done,
  output logic                           err,
  output logic [8*MAX_BYTES-1:0]         rdata,
  output logic                           bc_start,
  output logic                           bc_stop,
  output logic                           bc_read,
  output logic                           bc_write,
  output logic                           bc_ack_in,
  output logic [7:0]                     bc_din,
  input  logic                           bc_cmd_ack,
  input  logic                           bc_ack_out,
  input  logic [7:0]                     bc_dout,
  input  logic                           bc_al
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = MAX_BYTES > 1 ? $clog2(MAX_BYTES) : 1;
  state_t state, state_n;
  logic [NUM_REQ-1:0] grant_n, arb_gnt;
  logic [IW-1:0] own, own_n, arb_idx;
  logic arb_any, rnw_q, rnw_n, done_n, err_n;
  logic [BW-1:0] last_q, last_n, idx_q, idx_n;
  logic [MAX_BYTES-1:0][7:0] wbuf_q, wbuf_n, rbuf_q, rbuf_n;
  logic [4:0] cmd_q, cmd_n;
  logic [7:0] din_n;
  logic [8*MAX_BYTES-1:0] rdata_n;
  int l_eff;
  assign {bc_start, bc_stop, bc_read, bc_write, bc_ack_in} = cmd_q;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk(clk), .reset_n(reset_n), .req(req), .advance(state == DONE), .last_in(own),
    .gnt(arb_gnt), .gnt_idx(arb_idx), .any(arb_any)
  );
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      own <= '0;
      rnw_q <= 1'b0;
      last_q <= '0;
      idx_q <= '0;
      wbuf_q <= '0;
      rbuf_q <= '0;
      cmd_q <= CMD_NONE;
      bc_din <= '0;
      done <= 1'b0;
      err <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      own <= own_n;
      rnw_q <= rnw_n;
      last_q <= last_n;
      idx_q <= idx_n;
      wbuf_q <= wbuf_n;
      rbuf_q <= rbuf_n;
      cmd_q <= cmd_n;
      bc_din <= din_n;
      done <= done_n;
      err <= err_n;
      rdata <= rdata_n;
    end
  // Commands are registered on the same edge as grant, so the next command is loaded on the ack edge
  always_comb begin
    state_n = state;
    grant_n = grant;
    own_n = own;
    rnw_n = rnw_q;
    last_n = last_q;
    idx_n = idx_q;
    wbuf_n = wbuf_q;
    rbuf_n = rbuf_q;
    cmd_n = cmd_q;
    din_n = bc_din;
    done_n = 1'b0;
    err_n = err;
    rdata_n = rdata;
    l_eff = (len[arb_idx*3 +: 3] == 3'd0) ? 1 : int'(len[arb_idx*3 +: 3]);
    l_eff = (l_eff > MAX_BYTES) ? MAX_BYTES : l_eff;
    if (state == IDLE) begin
      if (arb_any) begin
        state_n = ADDR;
        grant_n = arb_gnt;
        own_n = arb_idx;
        rnw_n = rnw[arb_idx];
        last_n = BW'(l_eff - 1);
        idx_n = '0;
        err_n = 1'b0;
        rbuf_n = '0;
        wbuf_n = wdata[arb_idx*8*MAX_BYTES +: 8*MAX_BYTES];
        cmd_n = CMD_START | CMD_WRITE;
        din_n = {dev_addr[arb_idx*7 +: 7], rnw[arb_idx]};
      end
    end else if (state == DONE) begin
      state_n = IDLE;
      grant_n = '0;
    end else if (bc_al) begin
      state_n = DONE;
      cmd_n = CMD_NONE;
      err_n = 1'b1;
      done_n = 1'b1;
      rdata_n = rbuf_q;
    end else if (bc_cmd_ack) begin
      cmd_n = CMD_NONE;
      if (state == ADDR && bc_ack_out) begin
        state_n = STOP;
        err_n = 1'b1;
        cmd_n = CMD_STOP;
      end else if (state == ADDR) begin
        state_n = DATA;
        cmd_n = data_cmd(rnw_q, last_q == '0);
        din_n = wbuf_q[0];
      end else if (state == DATA) begin
        rbuf_n[idx_q] = rnw_q ? bc_dout : rbuf_q[idx_q];
        if (idx_q == last_q) begin
          state_n = DONE;
          done_n = 1'b1;
          rdata_n = rbuf_n;
        end else if (!rnw_q && bc_ack_out) begin
          state_n = STOP;
          err_n = 1'b1;
          cmd_n = CMD_STOP;
        end else begin
          idx_n = idx_q + BW'(1);
          cmd_n = data_cmd(rnw_q, idx_n == last_q);
          din_n = wbuf_q[idx_n];
        end
      end else begin
        state_n = DONE;
        done_n = 1'b1;
        rdata_n = rbuf_q;
      end
    end
  end
endmodule

// File: tb/tb_i2c_sequencer.sv
// tb_i2c_sequencer: byte-controller model, transfer-level reference model, directed table and random transfers
module tb_i2c_sequencer;
  localparam int NR = 4;
  localparam int MB = 4;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [NR-1:0] req = '0, rnw = '0;
  logic [NR*7-1:0] dev_addr = '0;
  logic [NR*3-1:0] len = '0;
  logic [NR*8*MB-1:0] wdata = '0;
  logic [NR-1:0] grant;
  logic done, err;
  logic [8*MB-1:0] rdata;
  logic bc_start, bc_stop, bc_read, bc_write, bc_ack_in;
  logic [7:0] bc_din, bc_dout;
  logic bc_cmd_ack, bc_ack_out, bc_al;

  i2c_sequencer #(.NUM_REQ(NR), .MAX_BYTES(MB)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .dev_addr(dev_addr), .rnw(rnw), .len(len), .wdata(wdata),
    .grant(grant), .done(done), .err(err), .rdata(rdata),
    .bc_start(bc_start), .bc_stop(bc_stop), .bc_read(bc_read), .bc_write(bc_write), .bc_ack_in(bc_ack_in),
    .bc_din(bc_din), .bc_cmd_ack(bc_cmd_ack), .bc_ack_out(bc_ack_out), .bc_dout(bc_dout), .bc_al(bc_al)
  );

  always #5 clk = ~clk;

  // command record: {start, stop, read, write, ack_in} plus the byte on bc_din
  typedef struct packed { logic [4:0] c; logic [7:0] d; } bcmd_t;
  typedef struct {
    int r; logic [6:0] a; logic rw; logic [2:0] l; logic [31:0] wd;
    logic na; int nb; int al; logic [31:0] rd;
    logic e_err; logic [31:0] e_rd; int e_n;
  } vec_t;

  bcmd_t log_q[$], exp_q[$];
  logic exp_err;
  logic [31:0] exp_rd;
  logic nack_addr = 1'b0;
  int nack_byte = -1, al_cmd = -1;
  logic [31:0] rd_word = '0;
  int cyc = 0, last_resp = 0, cnt = 0, cmd_no = 0;
  bit busy = 1'b0;
  int pass_n = 0, total_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // byte-controller model: acks each new command after 0..2 cycles, or raises bc_al when told to
  initial begin
    bc_cmd_ack = 1'b0; bc_ack_out = 1'b0; bc_dout = '0; bc_al = 1'b0;
    forever begin
      @(negedge clk);
      bc_cmd_ack = 1'b0;
      bc_al = 1'b0;
      if (!reset_n) busy = 1'b0;
      else begin
        if (!busy && (bc_start | bc_stop | bc_read | bc_write)) begin
          busy = 1'b1;
          cnt = $urandom_range(0, 2);
          cmd_no = bc_start ? 0 : cmd_no + 1;
          log_q.push_back('{c: {bc_start, bc_stop, bc_read, bc_write, bc_ack_in}, d: bc_din});
        end
        if (busy) begin
          if (cnt > 0) cnt--;
          else begin
            busy = 1'b0;
            last_resp = cyc;
            if (cmd_no == al_cmd && (bc_read || bc_write)) bc_al = 1'b1;
            else begin
              bc_cmd_ack = 1'b1;
              bc_ack_out = (cmd_no == 0) ? nack_addr : (bc_write && (cmd_no - 1 == nack_byte));
              bc_dout = (cmd_no >= 1 && cmd_no <= 4) ? rd_word[8*(cmd_no-1) +: 8] : 8'h00;
            end
          end
        end
      end
    end
  end

  // transfer-level expectation: command list, err and rdata from the slave behaviour knobs
  function automatic void model(input logic [6:0] a, input logic rw, input logic [2:0] l, input logic [31:0] wd);
    int n;
    logic [4:0] c;
    n = (l == 0) ? 1 : ((l > MB) ? MB : int'(l));
    exp_q.delete();
    exp_err = 1'b0;
    exp_rd = '0;
    exp_q.push_back('{c: 5'b10010, d: {a, rw}});
    if (al_cmd == 0) begin exp_err = 1'b1; return; end
    if (nack_addr) begin exp_q.push_back('{c: 5'b01000, d: 8'h00}); exp_err = 1'b1; return; end
    for (int b = 0; b < n; b++) begin
      c = {1'b0, b == n - 1, rw, ~rw, rw & (b == n - 1)};
      exp_q.push_back('{c: c, d: rw ? 8'h00 : wd[8*b +: 8]});
      if (al_cmd == b + 1) begin exp_err = 1'b1; return; end
      if (rw) exp_rd[8*b +: 8] = rd_word[8*b +: 8];
      else if (nack_byte == b && b < n - 1) begin
        exp_q.push_back('{c: 5'b01000, d: 8'h00});
        exp_err = 1'b1;
        return;
      end
    end
  endfunction

  task automatic run_txn(input string tag, input int r, input logic [6:0] a, input logic rw, input logic [2:0] l,
                         input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd, input int e_n);
    bit seen_g, seen_d;
    seen_g = 1'b0;
    seen_d = 1'b0;
    log_q.delete();
    dev_addr[r*7 +: 7] = a;
    rnw[r] = rw;
    len[r*3 +: 3] = l;
    wdata[r*32 +: 32] = wd;
    req[r] = 1'b1;
    for (int i = 0; i < 300 && !seen_d; i++) begin
      @(negedge clk);
      if (!seen_g && grant != '0) begin
        seen_g = 1'b1;
        chk({tag, " cmd with grant"}, {bc_start, bc_write}, 2'b11);
      end
      if (done) begin
        seen_d = 1'b1;
        chk({tag, " grant"}, grant, NR'(1) << r);
        chk({tag, " err"}, err, e_err);
        chk({tag, " rdata"}, rdata, e_rd);
        chk({tag, " done latency"}, cyc - last_resp, 1);
        chk({tag, " cmds idle at done"}, {bc_start, bc_stop, bc_read, bc_write}, 0);
      end
    end
    req[r] = 1'b0;
    chk({tag, " done seen"}, seen_d, 1);
    if (seen_d) begin
      @(negedge clk);
      chk({tag, " done pulse and grant clear"}, {done, grant}, 0);
    end
    chk({tag, " cmd count"}, log_q.size(), e_n);
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      chk($sformatf("%s cmd%0d bits", tag, k), log_q[k].c, exp_q[k].c);
      if (exp_q[k].c[1]) chk($sformatf("%s cmd%0d din", tag, k), log_q[k].d, exp_q[k].d);
    end
  endtask

  vec_t vt[9];
  logic [NR-1:0] gs[$];
  int rr;
  logic [6:0] ra;
  logic rrw;
  logic [2:0] rl;
  logic [31:0] rwd;

  initial begin
    vt[0] = '{0, 7'h50, 1'b0, 3'd2, 32'h0000BEEF, 1'b0, -1, -1, 32'h0,        1'b0, 32'h0,        3};
    vt[1] = '{2, 7'h1D, 1'b1, 3'd3, 32'h0,        1'b0, -1, -1, 32'h00332211, 1'b0, 32'h00332211, 4};
    vt[2] = '{1, 7'h7F, 1'b0, 3'd2, 32'h00001234, 1'b1, -1, -1, 32'h0,        1'b1, 32'h0,        2};
    vt[3] = '{3, 7'h22, 1'b0, 3'd3, 32'h00CCBBAA, 1'b0, -1,  2, 32'h0,        1'b1, 32'h0,        3};
    vt[4] = '{1, 7'h33, 1'b0, 3'd3, 32'h00332211, 1'b0,  0, -1, 32'h0,        1'b1, 32'h0,        3};
    vt[5] = '{2, 7'h41, 1'b0, 3'd2, 32'h00005566, 1'b0,  1, -1, 32'h0,        1'b0, 32'h0,        3};
    vt[6] = '{0, 7'h44, 1'b1, 3'd0, 32'h0,        1'b0, -1, -1, 32'h0000005A, 1'b0, 32'h0000005A, 2};
    vt[7] = '{3, 7'h2C, 1'b1, 3'd4, 32'h0,        1'b0, -1, -1, 32'hDDCCBBAA, 1'b0, 32'hDDCCBBAA, 5};
    vt[8] = '{1, 7'h10, 1'b1, 3'd2, 32'h0,        1'b0, -1,  1, 32'h00009988, 1'b1, 32'h0,        2};
    repeat (3) @(negedge clk);
    chk("reset outputs", {grant, done, err, rdata, bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int v = 0; v < 9; v++) begin
      nack_addr = vt[v].na;
      nack_byte = vt[v].nb;
      al_cmd = vt[v].al;
      rd_word = vt[v].rd;
      model(vt[v].a, vt[v].rw, vt[v].l, vt[v].wd);
      run_txn($sformatf("vec%0d", v), vt[v].r, vt[v].a, vt[v].rw, vt[v].l, vt[v].wd, vt[v].e_err, vt[v].e_rd, vt[v].e_n);
    end
    for (int t = 0; t < 40; t++) begin
      rr = $urandom_range(0, NR - 1);
      ra = 7'($urandom);
      rrw = 1'($urandom);
      rl = 3'($urandom_range(0, MB));
      rwd = $urandom;
      rd_word = $urandom;
      nack_addr = ($urandom_range(0, 7) == 0);
      nack_byte = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MB - 1)) : -1;
      al_cmd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MB)) : -1;
      model(ra, rrw, rl, rwd);
      run_txn($sformatf("rand%0d", t), rr, ra, rrw, rl, rwd, exp_err, exp_rd, exp_q.size());
    end
    // reset in the middle of a transfer owned by requester 1, after requester 0 was last served
    nack_addr = 1'b0; nack_byte = -1; al_cmd = -1; rd_word = 32'h000000A5;
    model(7'h12, 1'b1, 3'd1, 32'h0);
    run_txn("pre-reset read", 0, 7'h12, 1'b1, 3'd1, 32'h0, exp_err, exp_rd, exp_q.size());
    log_q.delete();
    dev_addr[7 +: 7] = 7'h21; rnw[1] = 1'b0; len[3 +: 3] = 3'd4; wdata[32 +: 32] = 32'h11223344;
    req[1] = 1'b1;
    for (int i = 0; i < 200 && log_q.size() < 3; i++) @(negedge clk);
    chk("reached second data byte", log_q.size() >= 3, 1);
    reset_n = 1'b0;
    req = '0;
    @(negedge clk);
    chk("mid-transfer reset grant", grant, 0);
    chk("mid-transfer reset done/err", {done, err}, 0);
    chk("mid-transfer reset rdata", rdata, 0);
    chk("mid-transfer reset bc outputs", {bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int r = 0; r < NR; r++) begin
      dev_addr[r*7 +: 7] = 7'(8'h30 + r); rnw[r] = 1'b0; len[r*3 +: 3] = 3'd1; wdata[r*32 +: 32] = 32'(r);
    end
    req = '1;
    for (int i = 0; i < 600 && gs.size() < 5; i++) begin
      @(negedge clk);
      if (done) gs.push_back(grant);
    end
    req = '0;
    chk("rr done count", gs.size(), 5);
    for (int k = 0; k < gs.size(); k++) begin
      chk($sformatf("rr grant %0d", k), gs[k], NR'(1) << (k % NR));
      if (k > 0) chk($sformatf("rr no repeat %0d", k), gs[k] != gs[k-1], 1);
    end
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
